// File: rtl/tc_pl_spi_pkg.sv
// Shared types and helpers for the tc_pl_spi_master SPI engine.
//   DEF_DATA_W / DEF_AGP0_25 : default transaction width and chip-select width
//   spi_state_e              : engine state encoding
//   eff_len()                : maps a requested bit count onto the usable range
//   max3()                   : sizing helper for the CS phase counter
package tc_pl_spi_pkg;

    localparam int unsigned DEF_DATA_W  = 24;
    localparam int unsigned DEF_AGP0_25 = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // A length of zero or beyond the data width means a full-width transfer.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned data_w);
        return ((len == 0) || (len > data_w)) ? data_w : len;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tc_pl_spi_master_if.sv
// Command/response bus of the SPI engine.
//   master : command issuer (drives cmd_*, observes ready/response/busy)
//   slave  : SPI engine (accepts cmd_*, returns rsp_*, cmd_ready, busy)
interface tc_pl_spi_master_if
    import tc_pl_spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned AGP0_25 = DEF_AGP0_25
);
    localparam int unsigned LEN_W = $clog2(DATA_W + 1);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [AGP0_25-1:0] cmd_sel;
    logic [LEN_W-1:0]   cmd_len;
    logic [DATA_W-1:0]  cmd_data;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               busy;

    modport master (
        output cmd_valid, cmd_sel, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/tc_pl_spi_sclk_gen.sv
// SCLK timing generator: counts CLK_DIV clk cycles per SCLK half period and
// flags the cycle whose closing edge must drive SCLK high (rise_c) or low (fall_c).
//   clk, rst : clock, synchronous active-high reset
//   en       : run enable; when low the divider restarts at the low phase
//   rise_c   : next edge drives SCLK 0->1
//   fall_c   : next edge drives SCLK 1->0
module tc_pl_spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_c,
    output logic fall_c
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] cnt_q;
    logic             high_q;
    logic             wrap_c;

    assign wrap_c = en && (cnt_q == DIV_W'(CLK_DIV - 1));
    assign rise_c = wrap_c && !high_q;
    assign fall_c = wrap_c && high_q;

    // Half-period divider; always restarts from the low phase when re-enabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else if (wrap_c) begin
            cnt_q  <= '0;
            high_q <= ~high_q;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tc_pl_spi_master.sv
// Single-channel SPI master, mode 0, MSB first.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : command/response bus (slave side)
//   chip_sel  : one-hot device select latched at command accept
//   spi_CSN   : active-low frame
//   spi_SCLK  : serial clock
//   spi_MOSI  : serial data out
//   spi_MISO  : serial data in from the chip-select fan-out
module tc_pl_spi_master
    import tc_pl_spi_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned AGP0_25  = DEF_AGP0_25,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    tc_pl_spi_master_if.slave  bus,
    output logic [AGP0_25-1:0] chip_sel,
    output logic               spi_CSN,
    output logic               spi_SCLK,
    output logic               spi_MOSI,
    input  logic               spi_MISO
);
    localparam int unsigned LEN_W = $clog2(DATA_W + 1);
    localparam int unsigned PH_W  = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

    spi_state_e         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [LEN_W-1:0]   bits_q, bits_d;
    logic [LEN_W-1:0]   len_eff;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [AGP0_25-1:0] sel_q, sel_d;
    logic               csn_q, csn_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               rise_c, fall_c;

    tc_pl_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == SHIFT),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bits_d      = bits_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        sel_d       = sel_q;
        csn_d       = csn_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        len_eff     = LEN_W'(eff_len(32'(bus.cmd_len), DATA_W));

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    state_d = SETUP;
                    phase_d = '0;
                    bits_d  = len_eff;
                    sel_d   = bus.cmd_sel;
                    // Left-align so the first bit to send is always the MSB.
                    shreg_d = bus.cmd_data << (DATA_W - 32'(len_eff));
                    rx_d    = '0;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = shreg_d[DATA_W-1];
                end
            end
            SETUP: begin
                if (phase_q == PH_W'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            SHIFT: begin
                if (rise_c) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], spi_MISO};
                end
                if (fall_c) begin
                    sclk_d = 1'b0;
                    if (bits_q == LEN_W'(1)) begin
                        // MOSI keeps the last bit through HOLD.
                        state_d = HOLD;
                        phase_d = '0;
                    end else begin
                        bits_d  = bits_q - LEN_W'(1);
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_q[DATA_W-2];
                    end
                end
            end
            HOLD: begin
                if (phase_q == PH_W'(CS_HOLD - 1)) begin
                    csn_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                    phase_d     = '0;
                    // The last gap cycle is spent in IDLE so accept lands CS_GAP after CSN rises.
                    state_d     = (CS_GAP > 1) ? GAP : IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            GAP: begin
                if (phase_q == PH_W'(CS_GAP - 2)) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bits_q      <= '0;
            shreg_q     <= '0;
            rx_q        <= '0;
            sel_q       <= '0;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bits_q      <= bits_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            sel_q       <= sel_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
    assign chip_sel      = sel_q;
    assign spi_CSN       = csn_q;
    assign spi_SCLK      = sclk_q;
    assign spi_MOSI      = mosi_q;

endmodule
